// File: rtl/ans_pkg.sv
// Shared types and constants for the ANS symbol-frequency table front end.
package ans_pkg;

    localparam int unsigned SYM_WIDTH = 4;
    localparam int unsigned CNT_WIDTH = 8;
    localparam int unsigned QW        = CNT_WIDTH + SYM_WIDTH;

    typedef enum logic [1:0] {
        READ_TYPE_NONE = 2'b00,
        READ_TYPE_PMF  = 2'b01,
        READ_TYPE_CMF  = 2'b10,
        READ_TYPE_ICMF = 2'b11
    } read_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } arb_state_t;

    // Index reached by stepping 'off' places past 'base' in a ring of n entries.
    function automatic int unsigned rr_index(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/ans_rr_pick.sv
// Combinational round-robin picker: first pending requester after last_grant.
module ans_rr_pick
    import ans_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDXW-1:0]    last_grant,
    output logic [IDXW-1:0]    winner,
    output logic               any_pending
);

    always_comb begin
        int unsigned idx;
        logic        found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = rr_index(32'(last_grant), k, NUM_REQ);
            if (!found && pending[idx]) begin
                winner = IDXW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_pending = |pending;

endmodule

// File: rtl/ans_table_arbiter.sv
// Round-robin arbiter sharing one frequency-table read port among NUM_REQ ANS requesters;
// one transaction in flight, result held until the winner changes or drops its request.
module ans_table_arbiter
    import ans_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned SYM_WIDTH = ans_pkg::SYM_WIDTH,
    parameter int unsigned CNT_WIDTH = ans_pkg::CNT_WIDTH,
    parameter int unsigned QW        = CNT_WIDTH + SYM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [2*NUM_REQ-1:0]    req_type,
    input  logic [QW*NUM_REQ-1:0]   req_query,
    output logic [QW*NUM_REQ-1:0]   req_result,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic [1:0]              tbl_type,
    output logic [QW-1:0]           tbl_query,
    output logic                    tbl_req,
    input  logic [QW-1:0]           tbl_result,
    input  logic                    tbl_done,
    output logic                    busy
);

    localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             state_q, state_d;
    logic [IDXW-1:0]        grant_q, grant_d;
    logic [IDXW-1:0]        last_grant_q, last_grant_d;
    logic [1:0]             lat_type_q, lat_type_d;
    logic [QW-1:0]          lat_query_q, lat_query_d;
    logic                   tbl_req_q, tbl_req_d;
    logic                   hold_q, hold_d;
    logic [QW*NUM_REQ-1:0]  result_q, result_d;

    logic [NUM_REQ-1:0]     pending;
    logic                   any_pending;
    logic [IDXW-1:0]        winner;
    logic [1:0]             win_type, cur_type;
    logic [QW-1:0]          win_query, cur_query;
    logic                   cur_match;

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = (req_type[2*i +: 2] != READ_TYPE_NONE);
        end
    end

    ans_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_pick (
        .pending     (pending),
        .last_grant  (last_grant_q),
        .winner      (winner),
        .any_pending (any_pending)
    );

    assign win_type  = req_type[2*winner +: 2];
    assign win_query = req_query[QW*winner +: QW];
    assign cur_type  = req_type[2*grant_q +: 2];
    assign cur_query = req_query[QW*grant_q +: QW];
    // Latched type is never NONE, so a NONE request also counts as a mismatch.
    assign cur_match = (cur_type == lat_type_q) && (cur_query == lat_query_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lat_type_d   = lat_type_q;
        lat_query_d  = lat_query_q;
        tbl_req_d    = 1'b0;
        hold_d       = hold_q;
        result_d     = result_q;
        unique case (state_q)
            IDLE: begin
                if (any_pending) begin
                    grant_d     = winner;
                    lat_type_d  = win_type;
                    lat_query_d = win_query;
                    tbl_req_d   = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (tbl_done) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_q == IDXW'(i)) begin
                            result_d[QW*i +: QW] = tbl_result;
                        end
                    end
                    hold_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!cur_match) begin
                    hold_d       = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            lat_type_q   <= READ_TYPE_NONE;
            lat_query_q  <= '0;
            tbl_req_q    <= 1'b0;
            hold_q       <= 1'b0;
            result_q     <= '0;
        end else if (ena) begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lat_type_q   <= lat_type_d;
            lat_query_q  <= lat_query_d;
            tbl_req_q    <= tbl_req_d;
            hold_q       <= hold_d;
            result_q     <= result_d;
        end
    end

    // Compare against live inputs so rdy drops in the very cycle the requester moves on.
    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy[i] = hold_q && (grant_q == IDXW'(i)) &&
                         (req_type[2*i +: 2] == lat_type_q) &&
                         (req_query[QW*i +: QW] == lat_query_q);
        end
    end

    // A strobe held back while ena is low stays registered and fires once ena returns.
    assign tbl_req    = tbl_req_q & ena;
    assign tbl_type   = lat_type_q;
    assign tbl_query  = lat_query_q;
    assign req_result = result_q;
    assign busy       = (state_q != IDLE);

endmodule
